// File: rtl/serial_display_pkg.sv
// Shared state encoding and default geometry for the serial display-chain shifter.
package serial_display_pkg;

    localparam int DEF_WORD_W   = 16;
    localparam int DEF_N_DEV    = 2;
    localparam int DEF_HALF_DIV = 2;
    localparam int DEF_GAP_CYC  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } shift_state_e;

endpackage

// File: rtl/sclk_phase_gen.sv
// SCK phase timer: while run is high, emits alternating rise/fall strobes every HALF_DIV cycles.
module sclk_phase_gen
    import serial_display_pkg::*;
#(
    parameter int HALF_DIV = DEF_HALF_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic run,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = $clog2(HALF_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic             phase_q;
    logic             tick;

    assign tick = run && (div_cnt_q == DIV_LAST);
    assign rise = tick && !phase_q;
    assign fall = tick && phase_q;

    // Restarting from zero whenever run drops keeps every frame's first low phase full length.
    always_ff @(posedge i_clk) begin
        if (i_reset || !run) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else if (tick) begin
            div_cnt_q <= '0;
            phase_q   <= !phase_q;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_chain_shifter.sv
// Shifts one frame of WORD_W*N_DEV bits into a chain of display drivers, then pulses LOAD high.
module serial_chain_shifter
    import serial_display_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int N_DEV    = DEF_N_DEV,
    parameter int HALF_DIV = DEF_HALF_DIV,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic                    i_lsb_first,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WORD_W*N_DEV-1:0] i_data,
    output logic                    o_busy,
    output logic                    o_serial_clk,
    output logic                    o_serial_dout,
    output logic                    o_serial_load
);

    localparam int BITS  = WORD_W * N_DEV;
    localparam int BIT_W = $clog2(BITS + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    shift_state_e     state_q, state_d;
    logic [BITS-1:0]  shreg_q, shreg_d;
    logic [BITS-1:0]  shifted;
    logic             lsb_q, lsb_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             ready_d, busy_d, sck_d, dout_d, load_d;
    logic             run, rise, fall;

    assign run = (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    sclk_phase_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_phase (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .run    (run),
        .rise   (rise),
        .fall   (fall)
    );

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        lsb_d     = lsb_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        sck_d     = o_serial_clk;
        dout_d    = o_serial_dout;
        load_d    = 1'b0;
        shifted   = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);

        unique case (state_q)
            ST_IDLE: begin
                busy_d  = 1'b0;
                load_d  = 1'b1;
                sck_d   = 1'b0;
                dout_d  = 1'b0;
                ready_d = i_en;
                if (i_valid && o_ready) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = i_data;
                    lsb_d     = i_lsb_first;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    load_d    = 1'b0;
                    dout_d    = i_lsb_first ? i_data[0] : i_data[BITS-1];
                end
            end
            ST_SHIFT: begin
                if (rise) begin
                    sck_d = 1'b1;
                end else if (fall) begin
                    sck_d     = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                        dout_d  = 1'b0;
                    end else begin
                        shreg_d = shifted;
                        dout_d  = lsb_q ? shifted[0] : shifted[BITS-1];
                    end
                end
            end
            ST_HOLD: begin
                sck_d = 1'b0;
                if (rise) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    load_d    = 1'b1;
                end
            end
            ST_GAP: begin
                load_d = 1'b1;
                sck_d  = 1'b0;
                dout_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = i_en;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            lsb_q         <= 1'b0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            o_ready       <= 1'b0;
            o_busy        <= 1'b0;
            o_serial_clk  <= 1'b0;
            o_serial_dout <= 1'b0;
            o_serial_load <= 1'b1;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            lsb_q         <= lsb_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            o_ready       <= ready_d;
            o_busy        <= busy_d;
            o_serial_clk  <= sck_d;
            o_serial_dout <= dout_d;
            o_serial_load <= load_d;
        end
    end

endmodule

// File: tb/tb_serial_chain_shifter.sv
// Bench for serial_chain_shifter: offset-based frame model checked every cycle, plus directed cases.
module tb_serial_chain_shifter;

    localparam int BITS_A  = 32;
    localparam int HD_A    = 2;
    localparam int GAP_A   = 4;
    localparam int SHIFT_A = 2 * HD_A * BITS_A;
    localparam int TOT_A   = SHIFT_A + HD_A + GAP_A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, lsb_a, valid_a;
    logic [31:0] data_a;
    logic        o_ready_a, o_busy_a, o_sck_a, o_dout_a, o_load_a;

    logic        rst_b, en_b, lsb_b, valid_b;
    logic [7:0]  data_b;
    logic        o_ready_b, o_busy_b, o_sck_b, o_dout_b, o_load_b;

    serial_chain_shifter dut_a (
        .i_clk        (clk),
        .i_reset      (rst_a),
        .i_en         (en_a),
        .i_lsb_first  (lsb_a),
        .i_valid      (valid_a),
        .o_ready      (o_ready_a),
        .i_data       (data_a),
        .o_busy       (o_busy_a),
        .o_serial_clk (o_sck_a),
        .o_serial_dout(o_dout_a),
        .o_serial_load(o_load_a)
    );

    serial_chain_shifter #(
        .WORD_W(8), .N_DEV(1), .HALF_DIV(1), .GAP_CYC(1)
    ) dut_b (
        .i_clk        (clk),
        .i_reset      (rst_b),
        .i_en         (en_b),
        .i_lsb_first  (lsb_b),
        .i_valid      (valid_b),
        .o_ready      (o_ready_b),
        .i_data       (data_b),
        .o_busy       (o_busy_b),
        .o_serial_clk (o_sck_b),
        .o_serial_dout(o_dout_b),
        .o_serial_load(o_load_b)
    );

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is described only by its offset k from the accept edge.
    bit          m_in_frame = 1'b0;
    bit          m_rst_s    = 1'b1;
    bit          m_en_s     = 1'b0;
    int          m_k        = 0;
    logic [31:0] m_data     = '0;
    logic        m_lsb      = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        logic        acc;
        logic [31:0] ow;
        acc = !m_in_frame && m_en_s && !m_rst_s && (valid_a === 1'b1);
        if (rst_a) begin
            if (m_in_frame && m_k <= SHIFT_A + HD_A && exp_q.size() > 0) ow = exp_q.pop_back();
            m_in_frame = 1'b0;
            m_rst_s    = 1'b1;
        end else begin
            m_rst_s = 1'b0;
            if (m_in_frame) begin
                m_k++;
                if (m_k > TOT_A) m_in_frame = 1'b0;
            end else if (acc) begin
                m_in_frame = 1'b1;
                m_k        = 1;
                m_data     = data_a;
                m_lsb      = lsb_a;
                for (int j = 0; j < BITS_A; j++)
                    ow[BITS_A-1-j] = lsb_a ? data_a[j] : data_a[BITS_A-1-j];
                exp_q.push_back(ow);
            end
        end
        m_en_s = en_a;
    end

    always @(negedge clk) begin
        logic [3:0] ec;
        logic       ed;
        bit         dcare;
        int         bi;
        if (cmp_on) begin
            dcare = 1'b0;
            ed    = 1'b0;
            if (m_in_frame) begin
                if (m_k <= SHIFT_A) begin
                    bi    = (m_k - 1) / (2 * HD_A);
                    ec    = {3'b010, ((m_k - 1) % (2 * HD_A)) >= HD_A};
                    ed    = m_data[m_lsb ? bi : BITS_A - 1 - bi];
                    dcare = 1'b1;
                end else if (m_k <= SHIFT_A + HD_A) begin
                    ec = 4'b0100;
                end else begin
                    ec = 4'b0110;
                end
            end else begin
                ec    = {m_en_s && !m_rst_s, 3'b010};
                dcare = 1'b1;
            end
            check("a_ctrl{ready,busy,load,sck}", 32'({o_ready_a, o_busy_a, o_load_a, o_sck_a}), 32'(ec));
            if (dcare) check("a_dout", 32'(o_dout_a), 32'(ed));
        end
    end

    // Receiver view of DUT A: bits sampled on SCK rise, frames delimited by LOAD.
    logic        prev_load = 1'b1;
    logic        prev_sck  = 1'b0;
    int          hi_len = 0, cap_cnt = 0, last_cnt = 0;
    int          frames_done = 0, frames_started = 0;
    logic [31:0] cap_word = '0, last_word = '0, want;
    int          gap_hist[$];

    always @(negedge clk) begin
        if (cmp_on) begin
            if (o_load_a) begin
                if (!prev_load) begin
                    frames_done++;
                    last_word = cap_word;
                    last_cnt  = cap_cnt;
                    if (cap_cnt == BITS_A) begin
                        if (exp_q.size() == 0) check("a_unexpected_frame_bits", 32'(cap_cnt), 0);
                        else begin
                            want = exp_q.pop_front();
                            check("a_stream_word", cap_word, want);
                        end
                    end
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev_load) begin
                    gap_hist.push_back(hi_len);
                    frames_started++;
                    cap_cnt  = 0;
                    cap_word = '0;
                end
                if (o_sck_a && !prev_sck) begin
                    cap_word = {cap_word[30:0], o_dout_a};
                    cap_cnt++;
                end
            end
            prev_load = o_load_a;
            prev_sck  = o_sck_a;
        end
    end

    task automatic send_a(input logic [31:0] d, input logic l, output int lat);
        int n;
        @(negedge clk);
        data_a = d; lsb_a = l; valid_a = 1'b1;
        n = 0;
        while (!o_ready_a && n < 400) begin @(negedge clk); n++; end
        check("a_accept_ready", 32'(o_ready_a), 1);
        @(negedge clk);
        valid_a = 1'b0; data_a = $urandom; lsb_a = ~l;
        lat = 1;
        while (!o_ready_a && lat < 400) begin @(negedge clk); lat++; end
    endtask

    task automatic run_b(input logic [7:0] d, input logic l, output int lat, output int rises,
                         output logic [7:0] w, output int period);
        int   t1;
        logic prev;
        @(negedge clk);
        check("b_ready_before", 32'(o_ready_b), 1);
        data_b = d; lsb_b = l; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0; data_b = ~d;
        lat = 1; rises = 0; w = '0; prev = 1'b0; t1 = -1; period = 0;
        while (!o_ready_b && lat < 100) begin
            if (o_sck_b && !prev) begin
                rises++;
                w = {w[6:0], o_dout_b};
                if (t1 < 0) t1 = lat;
                else if (period == 0) period = lat - t1;
            end
            prev = o_sck_b;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, rises, readies, started, b_lat, b_rises, b_period;
        logic prev;
        logic [7:0] b_word;

        rst_a = 1'b1; en_a = 1'b1; valid_a = 1'b0; lsb_a = 1'b0; data_a = '0;
        rst_b = 1'b1; en_b = 1'b1; valid_b = 1'b0; lsb_b = 1'b0; data_b = '0;
        repeat (3) @(posedge clk);
        cmp_on = 1'b1;
        @(negedge clk);
        check("rst_load", 32'(o_load_a), 1);
        check("rst_sck", 32'(o_sck_a), 0);
        check("rst_dout", 32'(o_dout_a), 0);
        check("rst_busy", 32'(o_busy_a), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(o_ready_a), 1);

        // MSB-first and LSB-first reference frames
        send_a(32'hA5C3_0F81, 1'b0, lat);
        check("msb_ready_latency", lat, 135);
        check("msb_pulses", last_cnt, 32);
        check("msb_word", last_word, 32'hA5C3_0F81);
        send_a(32'hA5C3_0F81, 1'b1, lat);
        check("lsb_ready_latency", lat, 135);
        check("lsb_word", last_word, 32'h81F0_C3A5);

        // valid held high across three frames
        gap_hist.delete();
        started = frames_done;
        @(negedge clk);
        valid_a = 1'b1;
        n = 0;
        while (frames_done < started + 3 && n < 1000) begin
            data_a = $urandom; lsb_a = 1'($urandom_range(0, 1));
            @(negedge clk); n++;
        end
        valid_a = 1'b0;
        check("b2b_frames", 32'(frames_done - started), 3);
        check("b2b_gap_1", (gap_hist.size() > 1) ? 32'(gap_hist[1]) : 32'hFFFF, GAP_A + 1);
        check("b2b_gap_2", (gap_hist.size() > 2) ? 32'(gap_hist[2]) : 32'hFFFF, GAP_A + 1);
        n = 0;
        while (!o_ready_a && n < 400) begin @(negedge clk); n++; end

        // reset during the tenth SCK pulse
        @(negedge clk);
        data_a = $urandom; lsb_a = 1'b0; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        n = 0; rises = 0; prev = 1'b0;
        while (rises < 10 && n < 400) begin
            if (o_sck_a && !prev) rises++;
            prev = o_sck_a;
            if (rises < 10) begin @(negedge clk); n++; end
        end
        check("abort_reached_pulse10", rises, 10);
        rst_a = 1'b1;
        @(negedge clk);
        check("abort_load", 32'(o_load_a), 1);
        check("abort_sck", 32'(o_sck_a), 0);
        check("abort_busy", 32'(o_busy_a), 0);
        rst_a = 1'b0;
        send_a(32'h1234_5678, 1'b0, lat);
        check("fresh_ready_latency", lat, 135);
        check("fresh_pulses", last_cnt, 32);
        check("fresh_word", last_word, 32'h1234_5678);

        // enable low blocks acceptance
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        valid_a = 1'b1;
        rises = 0; readies = 0; prev = o_sck_a;
        repeat (50) begin
            @(negedge clk);
            if (o_ready_a) readies++;
            if (o_sck_a && !prev) rises++;
            prev = o_sck_a;
        end
        check("en0_ready_seen", readies, 0);
        check("en0_sck_pulses", rises, 0);

        // enable dropped mid-frame: frame completes, no further accept
        en_a = 1'b1;
        n = 0;
        while (!o_busy_a && n < 50) begin @(negedge clk); n++; end
        check("endrop_started", 32'(o_busy_a), 1);
        repeat (20) @(negedge clk);
        en_a = 1'b0;
        started = frames_started;
        n = 0;
        while (o_busy_a && n < 400) begin @(negedge clk); n++; end
        check("endrop_completed_pulses", last_cnt, 32);
        repeat (60) @(negedge clk);
        check("endrop_no_new_frame", 32'(frames_started - started), 0);
        valid_a = 1'b0;
        en_a = 1'b1;

        // randomized traffic with enable toggling
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            valid_a = ($urandom_range(0, 3) == 0);
            en_a    = ($urandom_range(0, 7) != 0);
            lsb_a   = 1'($urandom_range(0, 1));
            data_a  = $urandom;
        end
        @(negedge clk);
        valid_a = 1'b0; en_a = 1'b1;
        n = 0;
        while (!o_ready_a && n < 400) begin @(negedge clk); n++; end
        check("rand_final_ready", 32'(o_ready_a), 1);
        check("rand_frames_outstanding", 32'(exp_q.size()), 0);

        // small configuration: 8 bits, HALF_DIV=1, GAP_CYC=1
        run_b(8'hB4, 1'b0, b_lat, b_rises, b_word, b_period);
        check("b_ready_latency", b_lat, 19);
        check("b_pulses", b_rises, 8);
        check("b_sck_period", b_period, 2);
        check("b_msb_word", 32'(b_word), 32'hB4);
        run_b(8'hB4, 1'b1, b_lat, b_rises, b_word, b_period);
        check("b_lsb_word", 32'(b_word), 32'h2D);
        check("b_lsb_latency", b_lat, 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
